// File: rtl/branch_tag_manager.sv
// rtl/branch_tag_manager.sv - branch tag allocation, resolve/squash tracking and mispredict recovery hold
// Optional occupancy outputs (tags_free, peak_live) are enabled with BTM_OCCUPANCY_EN.
`ifndef N
`define N 3
`endif
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

module branch_tag_manager #(
  parameter int N               = `N,
  parameter int B_MASK_WIDTH    = `B_MASK_WIDTH,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N-1:0]                          alloc_req,
  output logic [N-1:0]                          alloc_gnt,
  output logic [N-1:0][B_MASK_WIDTH-1:0]        alloc_tag,
  output logic [N-1:0][B_MASK_WIDTH-1:0]        alloc_dep_mask,
  output logic [$clog2(N+1)-1:0]                dispatch_limit,
  input  logic                                  resolve_valid,
  input  logic [B_MASK_WIDTH-1:0]               resolve_tag,
  input  logic                                  resolve_mispredict,
  output logic [B_MASK_WIDTH-1:0]               b_mask,
  output logic [B_MASK_WIDTH-1:0]               clear_mask,
  output logic [B_MASK_WIDTH-1:0]               squash_mask,
  output logic                                  restore_valid
`ifdef BTM_OCCUPANCY_EN
  ,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]     tags_free,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]     peak_live
`endif
);

  localparam int LW = $clog2(N+1);
  localparam int CW = $clog2(RECOVERY_CYCLES+1);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [B_MASK_WIDTH-1:0] r_b_mask;
  logic [B_MASK_WIDTH-1:0] r_dep [B_MASK_WIDTH];

  logic                    w_live_hit;
  logic                    w_correct;
  logic                    w_mispredict;
  logic [B_MASK_WIDTH-1:0] w_dep_hits;
  logic [B_MASK_WIDTH-1:0] w_granted;
  logic [B_MASK_WIDTH-1:0] w_avail;
  logic                    w_denied;
  logic [B_MASK_WIDTH-1:0] w_tag_dep [B_MASK_WIDTH];
  logic [B_MASK_WIDTH-1:0] w_next_b_mask;

  // Resolves naming a tag that is not live are dropped entirely.
  assign w_live_hit   = resolve_valid && |(resolve_tag & r_b_mask);
  assign w_correct    = w_live_hit && !resolve_mispredict;
  assign w_mispredict = w_live_hit && resolve_mispredict;

  always_comb begin
    w_dep_hits = '0;
    for (int j = 0; j < B_MASK_WIDTH; j++) begin
      w_dep_hits[j] = |(r_dep[j] & resolve_tag);
    end
  end

  // Stale dep rows of freed tags are masked off by the live set.
  assign clear_mask    = w_correct ? resolve_tag : '0;
  assign squash_mask   = w_mispredict ? ((resolve_tag | w_dep_hits) & r_b_mask) : '0;
  assign restore_valid = w_mispredict || (r_state == RECOVER);
  assign b_mask        = r_b_mask;

  always_comb begin
    alloc_gnt      = '0;
    alloc_tag      = '0;
    alloc_dep_mask = '0;
    dispatch_limit = LW'(N);
    w_granted      = '0;
    w_avail        = ~r_b_mask;
    w_denied       = 1'b0;
    for (int k = 0; k < B_MASK_WIDTH; k++) begin
      w_tag_dep[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      alloc_dep_mask[i] = r_b_mask | w_granted;
      if (!restore_valid && alloc_req[i] && !w_denied) begin
        if (|w_avail) begin
          alloc_tag[i] = w_avail & (-w_avail);
          alloc_gnt[i] = 1'b1;
          for (int k = 0; k < B_MASK_WIDTH; k++) begin
            if (alloc_tag[i][k]) w_tag_dep[k] = r_b_mask | w_granted;
          end
          w_granted = w_granted | alloc_tag[i];
          w_avail   = w_avail & ~alloc_tag[i];
        end else begin
          w_denied       = 1'b1;
          dispatch_limit = LW'(i);
        end
      end
    end
    if (restore_valid) dispatch_limit = '0;
  end

  assign w_next_b_mask = (r_b_mask | w_granted) & ~clear_mask & ~squash_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_b_mask <= '0;
      for (int j = 0; j < B_MASK_WIDTH; j++) r_dep[j] <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
    end else begin
      r_b_mask <= w_next_b_mask;
      // A tag resolving correctly in the grant cycle must not linger in the new dep row.
      for (int j = 0; j < B_MASK_WIDTH; j++) begin
        if (w_granted[j]) r_dep[j] <= w_tag_dep[j] & ~clear_mask;
        else              r_dep[j] <= r_dep[j] & ~clear_mask;
      end
      case (r_state)
        IDLE: begin
          if (w_mispredict) begin
            r_state <= RECOVER;
            r_cnt   <= CW'(RECOVERY_CYCLES);
          end
        end
        RECOVER: begin
          if (w_mispredict) begin
            r_cnt <= CW'(RECOVERY_CYCLES);
          end else if (r_cnt == CW'(1) || r_cnt == '0) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTM_OCCUPANCY_EN
  localparam int OW = $clog2(B_MASK_WIDTH+1);

  logic [OW-1:0] w_live_cnt;
  logic [OW-1:0] w_next_cnt;
  logic [OW-1:0] r_peak;

  always_comb begin
    w_live_cnt = '0;
    w_next_cnt = '0;
    for (int j = 0; j < B_MASK_WIDTH; j++) begin
      w_live_cnt = w_live_cnt + OW'(r_b_mask[j]);
      w_next_cnt = w_next_cnt + OW'(w_next_b_mask[j]);
    end
  end

  // Tracking the next live set keeps peak_live >= the current popcount every cycle.
  always_ff @(posedge clock) begin
    if (reset)                    r_peak <= '0;
    else if (w_next_cnt > r_peak) r_peak <= w_next_cnt;
  end

  assign tags_free = OW'(B_MASK_WIDTH) - w_live_cnt;
  assign peak_live = r_peak;
`endif

endmodule

// File: tb/tb_branch_tag_manager.sv
// tb/tb_branch_tag_manager.sv - randomized and directed bench for branch_tag_manager against a free-list model
module tb_branch_tag_manager;

  localparam int TN = 3;
  localparam int TB = 4;
  localparam int TR = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [TN-1:0]       alloc_req;
  logic [TN-1:0]       alloc_gnt;
  logic [TN-1:0][TB-1:0] alloc_tag;
  logic [TN-1:0][TB-1:0] alloc_dep_mask;
  logic [1:0]          dispatch_limit;
  logic                resolve_valid;
  logic [TB-1:0]       resolve_tag;
  logic                resolve_mispredict;
  logic [TB-1:0]       b_mask;
  logic [TB-1:0]       clear_mask;
  logic [TB-1:0]       squash_mask;
  logic                restore_valid;
`ifdef BTM_OCCUPANCY_EN
  logic [2:0]          tags_free;
  logic [2:0]          peak_live;
`endif

  branch_tag_manager #(.N(TN), .B_MASK_WIDTH(TB), .RECOVERY_CYCLES(TR)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .alloc_dep_mask(alloc_dep_mask), .dispatch_limit(dispatch_limit),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict), .b_mask(b_mask),
    .clear_mask(clear_mask), .squash_mask(squash_mask), .restore_valid(restore_valid)
`ifdef BTM_OCCUPANCY_EN
    , .tags_free(tags_free), .peak_live(peak_live)
`endif
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model: live set, per-tag dependency sets (zero for dead tags), cycles of recovery left.
  logic [TB-1:0] m_live;
  logic [TB-1:0] m_dep [TB];
  int            m_rec;

  logic [TN-1:0]         s_gnt;
  logic [TN-1:0][TB-1:0] s_tag, s_dep;
  logic [1:0]            s_limit;
  logic [TB-1:0]         s_clear, s_squash, s_bmask;
  logic                  s_restore;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [TN-1:0] req, input logic rv, input logic [TB-1:0] rt,
                       input logic rm, input logic rst);
    logic [TB-1:0]         granted, e_clear, e_squash;
    logic [TN-1:0]         e_gnt;
    logic [TN-1:0][TB-1:0] e_tag, e_dep;
    int                    e_limit, tg;
    logic                  e_restore, hit, denied;
    int                    free_q[$];
    alloc_req = req; resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm; reset = rst;
    #1;
    hit      = rv && ((rt & m_live) != '0);
    e_clear  = (hit && !rm) ? rt : '0;
    e_squash = '0;
    if (hit && rm) begin
      for (int t = 0; t < TB; t++) begin
        if (rt[t]) begin
          e_squash[t] = 1'b1;
          for (int j = 0; j < TB; j++) if (m_dep[j][t]) e_squash[j] = 1'b1;
        end
      end
    end
    e_restore = (hit && rm) || (m_rec > 0);
    for (int t = 0; t < TB; t++) if (!m_live[t]) free_q.push_back(t);
    granted = '0; denied = 1'b0; e_gnt = '0; e_tag = '0;
    e_limit = e_restore ? 0 : TN;
    for (int i = 0; i < TN; i++) begin
      e_dep[i] = m_live | granted;
      if (!e_restore && req[i] && !denied) begin
        if (free_q.size() > 0) begin
          tg = free_q.pop_front();
          e_gnt[i] = 1'b1;
          e_tag[i][tg] = 1'b1;
          granted[tg] = 1'b1;
        end else begin
          denied = 1'b1;
          e_limit = i;
        end
      end
    end
    check("alloc_gnt", 32'(alloc_gnt), 32'(e_gnt));
    check("alloc_tag", 32'(alloc_tag), 32'(e_tag));
    check("alloc_dep_mask", 32'(alloc_dep_mask), 32'(e_dep));
    check("dispatch_limit", 32'(dispatch_limit), 32'(e_limit));
    check("clear_mask", 32'(clear_mask), 32'(e_clear));
    check("squash_mask", 32'(squash_mask), 32'(e_squash));
    check("restore_valid", 32'(restore_valid), 32'(e_restore));
    check("b_mask", 32'(b_mask), 32'(m_live));
    s_gnt = alloc_gnt; s_tag = alloc_tag; s_dep = alloc_dep_mask; s_limit = dispatch_limit;
    s_clear = clear_mask; s_squash = squash_mask; s_bmask = b_mask; s_restore = restore_valid;
    @(posedge clock);
    if (rst) begin
      m_live = '0;
      for (int j = 0; j < TB; j++) m_dep[j] = '0;
      m_rec = 0;
    end else begin
      for (int i = 0; i < TN; i++)
        for (int t = 0; t < TB; t++)
          if (e_tag[i][t]) begin m_live[t] = 1'b1; m_dep[t] = e_dep[i]; end
      m_live = m_live & ~e_clear & ~e_squash;
      for (int j = 0; j < TB; j++) begin
        m_dep[j] = m_dep[j] & ~e_clear;
        if (e_clear[j] || e_squash[j]) m_dep[j] = '0;
      end
      if (hit && rm) m_rec = TR;
      else if (m_rec > 0) m_rec--;
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; alloc_req = '0; resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
    m_live = '0; m_rec = 0;
    for (int j = 0; j < TB; j++) m_dep[j] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);

    cycle(3'b000, 0, 4'b0000, 0, 0);
    check("reset_limit", 32'(s_limit), 32'd3);
    check("reset_restore", 32'(s_restore), 32'd0);
    cycle(3'b111, 0, 4'b0000, 0, 0);
    check("c1_tag", 32'(s_tag), 32'h421);
    check("c1_dep", 32'(s_dep), 32'h310);
    cycle(3'b011, 0, 4'b0000, 0, 0);
    check("c2_bmask", 32'(s_bmask), 32'b0111);
    check("c2_gnt", 32'(s_gnt), 32'b001);
    check("c2_limit", 32'(s_limit), 32'd1);
    cycle(3'b001, 1, 4'b0010, 0, 0);
    check("c3_clear", 32'(s_clear), 32'b0010);
    check("c3_bmask", 32'(s_bmask), 32'b1111);
    check("c3_no_regrant", 32'(s_gnt), 32'b000);
    cycle(3'b001, 0, 4'b0000, 0, 0);
    check("c4_bmask", 32'(s_bmask), 32'b1101);
    check("c4_tag", 32'(s_tag), 32'h002);
    cycle(3'b111, 1, 4'b0001, 1, 0);
    check("c5_squash", 32'(s_squash), 32'b1111);
    check("c5_gnt", 32'(s_gnt), 32'b000);
    cycle(3'b111, 0, 4'b0000, 0, 0);
    check("c6_restore", 32'(s_restore), 32'd1);
    cycle(3'b111, 0, 4'b0000, 0, 0);
    check("c7_restore", 32'(s_restore), 32'd1);
    cycle(3'b111, 0, 4'b0000, 0, 0);
    check("c8_restore", 32'(s_restore), 32'd0);
    check("c8_bmask", 32'(s_bmask), 32'b0000);
    check("c8_gnt", 32'(s_gnt), 32'b111);
    cycle(3'b000, 1, 4'b0100, 1, 0);
    cycle(3'b000, 1, 4'b0010, 1, 0);
    check("c10_squash", 32'(s_squash), 32'b0010);
    cycle(3'b000, 0, 4'b0000, 0, 0);
    cycle(3'b000, 0, 4'b0000, 0, 0);
    check("c12_restart", 32'(s_restore), 32'd1);
    cycle(3'b000, 1, 4'b1000, 1, 0);
    check("c13_nonlive_sq", 32'(s_squash), 32'b0000);
    check("c13_restore", 32'(s_restore), 32'd0);
    cycle(3'b000, 1, 4'b0001, 1, 0);
    check("c14_bmask", 32'(s_bmask), 32'b0001);
    cycle(3'b000, 1, 4'b0001, 1, 1);
    cycle(3'b000, 0, 4'b0000, 0, 0);
    check("c16_restore", 32'(s_restore), 32'd0);
    check("c16_bmask", 32'(s_bmask), 32'b0000);

    for (int n = 0; n < 600; n++) begin
      cycle(3'($urandom), ($urandom_range(1) == 1), 4'(1 << $urandom_range(TB-1)),
            ($urandom_range(6) == 0), ($urandom_range(60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_tag_manager.md
BRANCH_TAG_MANAGER -- requirements
Module: branch_tag_manager

Interface
REQ-001 The block SHALL take parameters: N, default `N, dispatch width; B_MASK_WIDTH, default `B_MASK_WIDTH, number of branch tags; RECOVERY_CYCLES, default 1, restore-hold length (>=1).
REQ-002 The block SHALL have ports (name direction width meaning):
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alloc_req  in  N  lane i holds a branch requesting a tag; lane 0 is oldest.
- alloc_gnt  out  N  tag granted to lane i.
- alloc_tag  out  N x B_MASK_WIDTH  one-hot tag per granted lane; zero otherwise.
- alloc_dep_mask  out  N x B_MASK_WIDTH  b_mask the lane's instruction carries.
- dispatch_limit  out  clog2(N+1)  index of first denied lane, or N if none denied.
- resolve_valid  in  1  a branch resolved this cycle.
- resolve_tag  in  B_MASK_WIDTH  one-hot tag of the resolving branch.
- resolve_mispredict  in  1  the resolving branch mispredicted.
- b_mask  out  B_MASK_WIDTH  registered set of live tags.
- clear_mask  out  B_MASK_WIDTH  tag freed by a correct resolve, for RS/ROB bit clearing.
- squash_mask  out  B_MASK_WIDTH  tags killed by a mispredict.
- restore_valid  out  1  recovery in progress; dispatch SHALL be inhibited.

Function
REQ-003 Grants SHALL be combinational from registered state: tags are handed out in lane order, lowest free tag index first.
REQ-004 A requesting lane SHALL be denied when no free tag remains; every lane after the first denied requesting lane SHALL get alloc_gnt=0.
REQ-005 dispatch_limit SHALL equal the first denied lane index, or N when no lane is denied.
REQ-006 alloc_dep_mask[i] SHALL equal b_mask OR the tags granted to lanes older than i in the same cycle.
REQ-007 Per tag t, the block SHALL store dep[t] = alloc_dep_mask of the lane granted t.
- Storage SHALL be written on the clock edge after the grant.
- The bit for t SHALL be set in b_mask on that same edge.
REQ-008 Correct resolve (resolve_valid=1, resolve_mispredict=0):
- clear_mask = resolve_tag, combinationally, in the same cycle.
- At the next edge: clear that bit in b_mask and in every dep[].
REQ-009 Mispredict on tag t:
- squash_mask = t OR every tag j with dep[j][t]=1, combinationally, in the same cycle.
- At the next edge: clear those bits from b_mask and enter RECOVER.
REQ-010 The FSM SHALL have two states: IDLE and RECOVER.
- IDLE -> RECOVER on a mispredict.
- RECOVER SHALL hold for exactly RECOVERY_CYCLES cycles, counted by a down-counter, then return to IDLE.
REQ-011 restore_valid SHALL be 1 in the mispredict cycle and throughout RECOVER.
- While restore_valid=1: alloc_gnt=0, dispatch_limit=0.
REQ-012 A mispredict arriving during RECOVER SHALL be applied per REQ-009 and SHALL reload the counter to RECOVERY_CYCLES.
REQ-013 A tag freed in cycle k SHALL NOT be granted before cycle k+1.
REQ-014 resolve_valid with a tag not set in b_mask SHALL be ignored: no state change, clear_mask=0, squash_mask=0.
REQ-015 When all B_MASK_WIDTH tags are live, every requesting lane SHALL be denied; non-branch lanes are unaffected (dispatch_limit = first requesting lane).

Reset
REQ-016 On reset: b_mask=0, all dep[]=0, FSM=IDLE, counter=0.
REQ-017 Outputs in the cycle after reset: alloc_gnt=0, clear_mask=0, squash_mask=0, restore_valid=0, dispatch_limit=N.
REQ-018 Reset SHALL override a concurrent resolve or mispredict, including one arriving mid-RECOVER.

Configuration
REQ-019 With BTM_OCCUPANCY_EN defined:
- Add output tags_free (clog2(B_MASK_WIDTH+1) bits) = B_MASK_WIDTH minus popcount(b_mask).
- Add output peak_live (same width), a registered high-water mark of popcount(b_mask), cleared by reset.
REQ-020 Without BTM_OCCUPANCY_EN defined, those ports and that logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Scenarios, with N=3, B_MASK_WIDTH=4, RECOVERY_CYCLES=2:
- Alloc: alloc_req=3'b111 from reset -> alloc_tag = 0001/0010/0100; alloc_dep_mask = 0000/0001/0011; next-cycle b_mask=0111.
- Full: then alloc_req=3'b011 -> lane0 gets 1000, lane1 denied, dispatch_limit=1, b_mask=1111 next cycle.
- Correct resolve: resolve tag 0010 correct -> clear_mask=0010; next cycle b_mask=1101 and dep[0100]=0001; that tag is not re-granted the same cycle.
- Mispredict: from b_mask=1111, mispredict tag 0001 -> squash_mask=1111; restore_valid high 3 cycles (mispredict cycle + 2); alloc_gnt=0 throughout; then b_mask=0000 and grants resume.
- Error/overlap: a second mispredict during RECOVER restarts the count; a resolve of a non-live tag produces no change; reset asserted mid-RECOVER gives restore_valid=0 the next cycle.
